// File: rtl/pts_4bit_sr_pkg.sv
// Package: pts_4bit_sr_pkg
// Purpose: shared constants for the parallel-to-serial shift register slice.
//   PTS_WIDTH : default register width used by the fixed-width wrapper
//   FILL_BIT  : value shifted into vacated positions; keeps the line idling high
package pts_4bit_sr_pkg;

  localparam int   PTS_WIDTH = 4;
  localparam logic FILL_BIT  = 1'b1;

endpackage

// File: rtl/pts_4bit_sr_flex.sv
// Module: flex_pts_sr
// Purpose: generic parallel-to-serial shift register. Loads a word in parallel
//   and shifts it out one bit per enabled clock, filling vacated positions
//   with FILL_BIT so the line idles high.
// Parameters:
//   NUM_BITS  : register width (must be >= 2)
//   SHIFT_MSB : 1 = MSB first (left shift), 0 = LSB first (right shift)
// Ports:
//   clk          in  system clock, rising edge
//   n_rst        in  synchronous active-low reset, loads all ones
//   shift_enable in  shift one position this cycle
//   load_enable  in  load parallel_in this cycle (priority over shift)
//   parallel_in  in  word to load
//   serial_out   out current output bit, taken straight from the register
module flex_pts_sr
  import pts_4bit_sr_pkg::*;
#(
  parameter int NUM_BITS  = PTS_WIDTH,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                load_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] q;
  logic [NUM_BITS-1:0] q_shifted;

  // Direction is fixed at elaboration, so only one slice expression is built.
  generate
    if (SHIFT_MSB) begin : g_msb_first
      assign q_shifted  = {q[NUM_BITS-2:0], FILL_BIT};
      assign serial_out = q[NUM_BITS-1];
    end else begin : g_lsb_first
      assign q_shifted  = {FILL_BIT, q[NUM_BITS-1:1]};
      assign serial_out = q[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      q <= '1;
    end else if (load_enable) begin
      q <= parallel_in;
    end else if (shift_enable) begin
      q <= q_shifted;
    end
  end

endmodule

// File: rtl/pts_4bit_sr.sv
// Module: pts_4bit_sr
// Purpose: fixed 4-bit, MSB-first parallel-to-serial shift register for serial
//   transmit datapaths. Thin wrapper around flex_pts_sr.
// Ports:
//   clk          in  system clock, rising edge
//   n_rst        in  synchronous active-low reset (register -> 4'b1111)
//   shift_enable in  shift one position this cycle
//   load_enable  in  load parallel_in this cycle (priority over shift)
//   parallel_in  in  4-bit word to load
//   serial_out   out registered serial output, idles high
module pts_4bit_sr
  import pts_4bit_sr_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 shift_enable,
  input  logic                 load_enable,
  input  logic [PTS_WIDTH-1:0] parallel_in,
  output logic                 serial_out
);

  flex_pts_sr #(
    .NUM_BITS  (PTS_WIDTH),
    .SHIFT_MSB (1'b1)
  ) u_flex_pts_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .load_enable  (load_enable),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out)
  );

endmodule

// File: tb/tb_pts_4bit_sr.sv
// Testbench: tb_pts_4bit_sr
// Purpose: self-checking bench for pts_4bit_sr. Directed scenarios plus a
//   randomized run, checked against a word-level arithmetic model.
module tb_pts_4bit_sr;

  logic       clk;
  logic       n_rst;
  logic       shift_enable;
  logic       load_enable;
  logic [3:0] parallel_in;
  logic       serial_out;

  int checks;
  int errors;

  // Reference model: the pending word as an integer; shifting MSB-first with
  // ones fill is (w*2 + 1) mod 16, and the line shows the top bit.
  int model_word;

  pts_4bit_sr dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .load_enable  (load_enable),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_out();
    return logic'((model_word / 8) % 2);
  endfunction

  // Drive one cycle of inputs (changed on the falling edge), let the rising
  // edge happen, then advance the model. Sampling happens 1 ns after the edge.
  task automatic step(input logic rst_v, input logic ld, input logic sh,
                      input logic [3:0] p);
    @(negedge clk);
    n_rst        = rst_v;
    load_enable  = ld;
    shift_enable = sh;
    parallel_in  = p;
    @(posedge clk);
    #1;
    if (!rst_v)      model_word = 15;
    else if (ld)     model_word = int'(p);
    else if (sh)     model_word = (model_word * 2 + 1) % 16;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    step(1'b1, 1'b0, 1'b0, 4'b1111);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_out got %b exp %b", serial_out, 1'b1);
    end
    checks++;
    if (dut.u_flex_pts_sr.q !== 4'b1111) begin
      errors++;
      $display("FAIL reset_q got %b exp %b", dut.u_flex_pts_sr.q, 4'b1111);
    end
    // Load zeros, then drop n_rst between edges: output must not move yet.
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    n_rst       = 1'b0;
    load_enable = 1'b0;
    #2;
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cycle got %b exp %b", serial_out, 1'b0);
    end
    @(posedge clk);
    #1;
    model_word = 15;
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_after_edge got %b exp %b", serial_out, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_load_priority();
    logic [3:0] vals [3] = '{4'b0000, 4'b1010, 4'b0111};
    logic       exp  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, vals[i]);
      checks++;
      if (serial_out !== exp[i]) begin
        errors++;
        $display("FAIL load_priority[%0d] got %b exp %b", i, serial_out, exp[i]);
      end
      checks++;
      if (dut.u_flex_pts_sr.q !== vals[i]) begin
        errors++;
        $display("FAIL load_priority_q[%0d] got %b exp %b", i,
                 dut.u_flex_pts_sr.q, vals[i]);
      end
    end
  endtask

  task automatic test_msb_shift();
    logic exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b1, 1'b1, 1'b0, 4'b1010);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b1, 1'b0, 1'b1, 4'b0000);
      checks++;
      if (serial_out !== exp[i]) begin
        errors++;
        $display("FAIL msb_shift[%0d] got %b exp %b", i, serial_out, exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b1, 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'b1111);
      checks++;
      if (serial_out !== 1'b0 || dut.u_flex_pts_sr.q !== 4'b0010) begin
        errors++;
        $display("FAIL hold[%0d] got out=%b q=%b exp out=0 q=0010", i,
                 serial_out, dut.u_flex_pts_sr.q);
      end
    end
    step(1'b1, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_shift1 got %b exp %b", serial_out, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL hold_shift2 got %b exp %b", serial_out, 1'b1);
    end
  endtask

  task automatic test_load_1000();
    logic exp [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(1'b1, 1'b1, 1'b0, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b1, 1'b0, 1'b1, 4'b0101);
      checks++;
      if (serial_out !== exp[i]) begin
        errors++;
        $display("FAIL load_1000[%0d] got %b exp %b", i, serial_out, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 4'b0000);
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op_shift got %b exp %b", serial_out, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    checks++;
    if (serial_out !== 1'b1 || dut.u_flex_pts_sr.q !== 4'b1111) begin
      errors++;
      $display("FAIL reset_mid_op got out=%b q=%b exp out=1 q=1111",
               serial_out, dut.u_flex_pts_sr.q);
    end
    step(1'b1, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_random();
    logic r, l, s;
    logic [3:0] p;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 2) != 0);
      p = 4'($urandom_range(0, 15));
      step(r, l, s, p);
      checks++;
      if (serial_out !== model_out() || int'(dut.u_flex_pts_sr.q) != model_word) begin
        errors++;
        $display("FAIL random[%0d] got out=%b q=%b exp out=%b q=%0d", i,
                 serial_out, dut.u_flex_pts_sr.q, model_out(), model_word);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    model_word   = 15;
    n_rst        = 1'b0;
    shift_enable = 1'b0;
    load_enable  = 1'b0;
    parallel_in  = 4'b1111;
    test_reset();
    test_load_priority();
    test_msb_shift();
    test_hold();
    test_load_1000();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
